gen_mem_handshake_tx: RTL and testbench

- Hardware-to-software word transfer stage. Buffers words from the genetic-circuit engine in a small FIFO and presents them one at a time to the Nios side on mem_data/mem_req, which feed input PIOs.
- Consumes the 1-bit acknowledge driven by the software-written mem_ack_data PIO output and completes a four-phase req/ack handshake per word.
- Sits directly downstream of the ack PIO: mem_ack here is that PIO's out_port.

---
 rtl/gen_mem_handshake_tx.sv | 137 +++++++++++++
 tb/tb_gen_mem_handshake_tx.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_mem_handshake_tx.sv
// Hardware-to-software word transfer: FIFO-buffered engine words presented to the
// Nios side one at a time over a four-phase mem_req/mem_ack handshake.
module gen_mem_handshake_tx #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W:0]   fifo_level,
    output logic              busy,
    output logic              timeout_err,
    input  logic              clr_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned LVL_W = ADDR_W + 1;
    localparam int unsigned CNT_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REL
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_W-1:0]      mem_q [DEPTH];
    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic                   mem_req_q, mem_req_d;
    logic [DATA_W-1:0]      mem_data_q, mem_data_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   push, pop, ack_s, tmr_run;

    assign ack_s       = ack_sync_q[SYNC_STAGES-1];
    assign in_ready    = (level_q != LVL_W'(DEPTH));
    assign mem_req     = mem_req_q;
    assign mem_data    = mem_data_q;
    assign fifo_level  = level_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = err_q;

    always_comb begin
        ack_sync_d[0] = mem_ack;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            ack_sync_d[i] = ack_sync_q[i-1];
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        mem_data_d = mem_data_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                // A still-high ack from the previous word must drop before the next word goes out.
                if (level_q != '0 && !ack_s) begin
                    pop        = 1'b1;
                    mem_data_d = mem_q[rd_ptr_q];
                    state_d    = REQ;
                end
            end
            REQ:     if (ack_s)  state_d = REL;
            REL:     if (!ack_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        mem_req_d = (state_d == REQ);
    end

    always_comb begin
        push     = in_valid && in_ready;
        wr_ptr_d = wr_ptr_q + ADDR_W'(push);
        rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    end

    always_comb begin
        tmr_run = (state_q != IDLE) && (state_d == state_q);
        cnt_d   = '0;
        err_d   = err_q;
        if (tmr_run) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
        if (clr_err) begin
            err_d = 1'b0;
        end
        // Set wins over clear; a saturated counter never re-fires after a clear.
        if (TIMEOUT_CYC != 0 && tmr_run && cnt_q == CNT_MAX - CNT_W'(1)) begin
            err_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_data_q <= '0;
            ack_sync_q <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            mem_req_q  <= mem_req_d;
            mem_data_q <= mem_data_d;
            ack_sync_q <= ack_sync_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    // NOTE: storage is not reset; the pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_gen_mem_handshake_tx.sv
// Directed plus randomized bench for gen_mem_handshake_tx against a queue-based
// handshake model; every cycle's outputs are compared on the falling edge.
module tb_gen_mem_handshake_tx;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;
    localparam int SYNC   = 2;
    localparam int TO     = 20;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk      = 1'b0;
    logic              reset_n  = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data  = '0;
    logic              mem_ack  = 1'b0;
    logic              clr_err  = 1'b0;
    logic              in_ready;
    logic              mem_req;
    logic [DATA_W-1:0] mem_data;
    logic [ADDR_W:0]   fifo_level;
    logic              busy;
    logic              timeout_err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: waiting words, transfer phase (0 idle, 1 requesting, 2 releasing),
    // word on the bus, ack sample history, timeout count and flag.
    logic [DATA_W-1:0] m_fifo[$];
    int                m_phase = 0;
    logic [DATA_W-1:0] m_data  = '0;
    logic              m_hist[$];
    int                m_cnt   = 0;
    logic              m_err   = 1'b0;

    gen_mem_handshake_tx #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .SYNC_STAGES(SYNC),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_data   (mem_data),
        .fifo_level (fifo_level),
        .busy       (busy),
        .timeout_err(timeout_err),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_hist.delete();
        m_phase = 0;
        m_data  = '0;
        m_cnt   = 0;
        m_err   = 1'b0;
    endtask

    task automatic model_edge();
        logic ack_s;
        logic set;
        int   nxt;
        int   sz;
        ack_s = (m_hist.size() == SYNC) ? m_hist[0] : 1'b0;
        sz    = m_fifo.size();
        nxt   = m_phase;
        set   = 1'b0;
        if (m_phase == 0 && sz > 0 && !ack_s) begin
            m_data = m_fifo.pop_front();
            nxt    = 1;
        end else if (m_phase == 1 && ack_s) begin
            nxt = 2;
        end else if (m_phase == 2 && !ack_s) begin
            nxt = 0;
        end
        if (in_valid && sz != DEPTH) m_fifo.push_back(in_data);
        if (nxt != m_phase || nxt == 0) begin
            m_cnt = 0;
        end else if (m_cnt < TO) begin
            m_cnt++;
            if (m_cnt == TO) set = 1'b1;
        end
        if (set) m_err = 1'b1;
        else if (clr_err) m_err = 1'b0;
        m_phase = nxt;
        m_hist.push_back(mem_ack);
        if (m_hist.size() > SYNC) void'(m_hist.pop_front());
    endtask

    task automatic cmp_all(input string tag);
        check({tag, ".req"},   32'(mem_req),     32'(m_phase == 1));
        check({tag, ".busy"},  32'(busy),        32'(m_phase != 0));
        check({tag, ".data"},  mem_data,         m_data);
        check({tag, ".level"}, 32'(fifo_level),  32'(m_fifo.size()));
        check({tag, ".ready"}, 32'(in_ready),    32'(m_fifo.size() != DEPTH));
        check({tag, ".err"},   32'(timeout_err), 32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_edge();
        @(negedge clk);
        cmp_all("cyc");
    endtask

    // Software side: wait for the request, ack after a random delay, release after another.
    task automatic sw_ack(input logic [31:0] exp_word, input string tag);
        int n;
        n = 0;
        while (m_phase != 1 && n < 100) begin tick(); n++; end
        check({tag, ".req"},  32'(mem_req), 32'd1);
        check({tag, ".word"}, mem_data, exp_word);
        repeat ($urandom_range(0, 3)) tick();
        mem_ack = 1'b1;
        n = 0;
        while (m_phase == 1 && n < 100) begin tick(); n++; end
        repeat ($urandom_range(0, 3)) tick();
        mem_ack = 1'b0;
        n = 0;
        while (m_phase == 2 && n < 100) begin tick(); n++; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dly;
        int n;

        // Reset state
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_reset();
        cmp_all("rst");
        check("rst.in_ready", 32'(in_ready), 32'd1);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Single word with fixed software timing
        in_valid = 1'b1;
        in_data  = 32'hA5A5_0001;
        tick();
        in_valid = 1'b0;
        check("t1.req_edge1", 32'(mem_req), 32'd0);
        tick();
        check("t1.req_edge2", 32'(mem_req), 32'd1);
        check("t1.data", mem_data, 32'hA5A5_0001);
        repeat (3) tick();
        mem_ack = 1'b1;
        repeat (SYNC) tick();
        check("t1.req_hold", 32'(mem_req), 32'd1);
        tick();
        check("t1.req_fall", 32'(mem_req), 32'd0);
        check("t1.level", 32'(fifo_level), 32'd0);
        repeat (3) tick();
        mem_ack = 1'b0;
        repeat (SYNC + 1) tick();
        check("t1.busy_idle", 32'(busy), 32'd0);

        // Fill and burst: nine back-to-back words, no ack
        for (int i = 1; i <= 9; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            tick();
        end
        in_valid = 1'b0;
        check("t2.full_level", 32'(fifo_level), 32'd8);
        check("t2.full_ready", 32'(in_ready), 32'd0);
        check("t2.first_word", mem_data, 32'd1);
        sw_ack(32'd1, "t2.w1");
        tick();
        check("t2.ready_back", 32'(in_ready), 32'd1);
        check("t2.level_7", 32'(fifo_level), 32'd7);
        for (int i = 2; i <= 9; i++) sw_ack(32'(i), "t2.w");

        // Simultaneous push and pop at level 3
        mem_ack = 1'b1;
        repeat (SYNC) tick();
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h3000_0000 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        check("t3.level_pre", 32'(fifo_level), 32'd3);
        mem_ack = 1'b0;
        repeat (SYNC) tick();
        in_valid = 1'b1;
        in_data  = 32'h3000_0004;
        tick();
        in_valid = 1'b0;
        check("t3.level_same", 32'(fifo_level), 32'd3);
        check("t3.req", 32'(mem_req), 32'd1);
        for (int i = 1; i <= 4; i++) sw_ack(32'h3000_0000 + 32'(i), "t3.w");

        // Stale ack held high while a word arrives
        mem_ack = 1'b1;
        repeat (SYNC) tick();
        in_valid = 1'b1;
        in_data  = 32'd7;
        tick();
        in_valid = 1'b0;
        repeat (4) begin
            tick();
            check("t4.stale_low", 32'(mem_req), 32'd0);
        end
        mem_ack = 1'b0;
        repeat (SYNC) begin
            tick();
            check("t4.sync_low", 32'(mem_req), 32'd0);
        end
        tick();
        check("t4.rise", 32'(mem_req), 32'd1);
        sw_ack(32'd7, "t4.w");

        // Timeout: no ack for a long time
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t5.clear0", 32'(timeout_err), 32'd0);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_0005;
        tick();
        in_valid = 1'b0;
        tick();
        check("t5.in_req", 32'(mem_req), 32'd1);
        repeat (TO - 1) tick();
        check("t5.err_before", 32'(timeout_err), 32'd0);
        tick();
        check("t5.err_set", 32'(timeout_err), 32'd1);
        check("t5.req_held", 32'(mem_req), 32'd1);
        repeat (3) tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t5.err_clr", 32'(timeout_err), 32'd0);
        repeat (5) tick();
        check("t5.err_stays", 32'(timeout_err), 32'd0);
        sw_ack(32'hDEAD_0005, "t5.w");

        // Reset in the middle of a transfer
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h6000_0000 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        check("t6.level_4", 32'(fifo_level), 32'd4);
        reset_n = 1'b0;
        #1;
        check("t6.req_async",   32'(mem_req),    32'd0);
        check("t6.busy_async",  32'(busy),       32'd0);
        check("t6.level_async", 32'(fifo_level), 32'd0);
        check("t6.ready_async", 32'(in_ready),   32'd1);
        model_reset();
        tick();
        tick();
        reset_n = 1'b1;
        repeat (10) begin
            tick();
            check("t6.no_stale", 32'(mem_req), 32'd0);
        end

        // Randomized traffic with a reactive software side
        dly = 0;
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 1) == 1);
            in_data  = $urandom();
            clr_err  = ($urandom_range(0, 15) == 0);
            if (dly > 0) begin
                dly--;
            end else if (!mem_ack && m_phase == 1) begin
                mem_ack = 1'b1;
                dly = $urandom_range(0, 4);
            end else if (mem_ack && m_phase == 2) begin
                mem_ack = 1'b0;
                dly = $urandom_range(0, 4);
            end
            tick();
        end
        in_valid = 1'b0;
        clr_err  = 1'b0;
        n = 0;
        while ((m_fifo.size() > 0 || m_phase != 0) && n < 2000) begin
            if (dly > 0) begin
                dly--;
            end else if (!mem_ack && m_phase == 1) begin
                mem_ack = 1'b1;
                dly = $urandom_range(0, 4);
            end else if (mem_ack && m_phase == 2) begin
                mem_ack = 1'b0;
                dly = $urandom_range(0, 4);
            end
            tick();
            n++;
        end
        check("rnd.drain_level", 32'(fifo_level), 32'd0);
        check("rnd.drain_busy",  32'(busy),       32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
